integration_led_sequencer: RTL and testbench
============================================

Name: integration_led_sequencer

Overview:
- Avalon-MM master that owns the LED PIO slave port (s1) and shares it between two requesters plus an internal auto-rotate pattern generator.
- Each accepted request is written to the PIO data register, read back and compared; mismatches set a sticky error flag.
- Sits between the S4PU/CPU-side status sources and the 16-bit LED PIO in the integration system.

Parameters:
- TICK_DIV, 50000000, clock cycles between auto-rotate steps; must be at least 2.
- RESET_PATTERN, 16'h3136, shadow value after reset; matches the PIO's own reset value.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- req0_valid  in  1  requester 0 has a pattern
- req0_data  in  16  requester 0 pattern
- req0_ready  out  1  requester 0 pattern accepted this cycle
- req1_valid  in  1  requester 1 has a pattern
- req1_data  in  16  requester 1 pattern
- req1_ready  out  1  requester 1 pattern accepted this cycle
- auto_en  in  1  enable auto-rotate source
- err_clr  in  1  clear sticky error
- pio_address  out  2  PIO address; always 0
- pio_chipselect  out  1  PIO chip select
- pio_write_n  out  1  PIO write strobe, active low
- pio_writedata  out  32  {16'b0, pattern}
- pio_readdata  in  32  PIO read data; combinational from PIO
- busy  out  1  transaction in progress (state != IDLE)
- current  out  16  shadow copy of the last verified pattern
- err  out  1  sticky read-back mismatch flag

Behaviour:
- Reset values: chipselect=0, write_n=1, address=0, writedata=0, both ready outputs=0, busy=0, current=RESET_PATTERN, err=0, state=IDLE, tick counter=0, tick_pending=0, rr pointer=1 (so req0 wins first).
- FSM states: IDLE, WRITE, READ, CHECK; one cycle each except IDLE.
- IDLE:
  - When any source is eligible, assert that source's ready combinationally in the same cycle.
  - Latch its pattern into the pending register (pend) and go to WRITE.
  - No other source is granted that cycle.
- WRITE: chipselect=1, write_n=0, writedata={16'b0, pend}; go to READ.
- READ: chipselect=1, write_n=1; capture pio_readdata[15:0] into rb at the clock edge; go to CHECK.
- CHECK: bus idle (chipselect=0, write_n=1).
  - If rb != pend, set err.
  - current <= pend unconditionally.
  - Go to IDLE.
- Throughput: one transaction per 4 cycles. A source held valid is re-arbitrated in the IDLE cycle after CHECK.
- Arbitration among req0 and req1:
  - Round-robin. When both are valid, grant the one not granted last; the pointer updates only on a req0/req1 grant.
  - A single valid requester is always granted.
- Auto source:
  - Lowest priority; eligible only when tick_pending=1 and neither requester is valid.
  - Pattern = rotate-left-by-1 of current, i.e. {current[14:0], current[15]}.
  - Granting it clears tick_pending.
- Tick counter:
  - Counts 0..TICK_DIV-1 while auto_en=1. On wrap it sets tick_pending; a tick while tick_pending is already 1 is lost.
  - auto_en=0 clears the counter and tick_pending synchronously.
- Error flag: err_clr clears err; if a mismatch set and err_clr occur in the same cycle, set wins.
- Requester data is sampled only in the grant cycle; later changes to data or valid do not affect the in-flight transaction.
- Reset mid-transaction: immediately drops chipselect, returns to IDLE and discards pend. A partially issued write is not retried.
- Width rules: pio_writedata[31:16] is always 0; pio_readdata[31:16] is ignored.

Test Plan:
- Reset release -> current=16'h3136, err=0, chipselect=0, write_n=1; no bus activity with no requests.
- req0_valid=1, req0_data=16'hA5A5 in IDLE:
  - req0_ready pulses 1 cycle.
  - Next cycle: write of 32'h0000A5A5 with write_n=0.
  - Then a read cycle, then CHECK.
  - current=16'hA5A5 four cycles after grant; err=0.
- req0 and req1 both held valid with 16'h0001 and 16'h0002 -> grants alternate req0, req1, req0, … every 4 cycles.
- TICK_DIV=4, auto_en=1, current=16'h8001, no requests -> after a tick, write of 16'h0003; then 16'h0006 on the next tick.
- Bench PIO model returns 16'h0000 for a write of 16'h00FF -> err=1 after CHECK.
  - err_clr alone clears it.
  - err_clr asserted in the same cycle as a new mismatch leaves err=1.
- Assert reset during WRITE of 16'h1234 -> chipselect=0 within the reset, state IDLE, current=16'h3136, no READ cycle issued.

Source files
------------

// File: rtl/integration_led_sequencer.sv
// Avalon-MM master for the 16-bit LED PIO (s1). It arbitrates between two
// requesters and an auto-rotate generator. Each granted pattern is written,
// read back and compared, and a mismatch sets a sticky error flag.
module integration_led_sequencer #(
  parameter int unsigned TICK_DIV      = 50000000,
  parameter logic [15:0] RESET_PATTERN = 16'h3136
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req0_valid,
  input  logic [15:0] req0_data,
  output logic        req0_ready,
  input  logic        req1_valid,
  input  logic [15:0] req1_data,
  output logic        req1_ready,
  input  logic        auto_en,
  input  logic        err_clr,
  output logic [1:0]  pio_address,
  output logic        pio_chipselect,
  output logic        pio_write_n,
  output logic [31:0] pio_writedata,
  input  logic [31:0] pio_readdata,
  output logic        busy,
  output logic [15:0] current,
  output logic        err
);

  localparam int unsigned CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  typedef enum logic [1:0] {IDLE, WRITE, READ, CHECK} state_t;

  state_t         state_q, state_d;
  logic [15:0]    pend_q, pend_d;
  logic [15:0]    rb_q, rb_d;
  logic [15:0]    current_q, current_d;
  logic           err_q, err_d;
  logic           rr_q, rr_d;          // last granted requester: 0 = req0, 1 = req1
  logic [CW-1:0]  tick_cnt_q, tick_cnt_d;
  logic           tick_pend_q, tick_pend_d;

  logic           grant0, grant1, auto_elig, auto_grant, tick_wrap;
  logic           unused_rd_hi;

  assign unused_rd_hi = ^pio_readdata[31:16];

  assign grant0    = req0_valid && (!req1_valid || rr_q);
  assign grant1    = req1_valid && (!req0_valid || !rr_q);
  assign auto_elig = tick_pend_q && !req0_valid && !req1_valid;
  assign tick_wrap = (tick_cnt_q == CW'(TICK_DIV - 1));

  assign pio_address = '0;
  assign busy        = (state_q != IDLE);
  assign current     = current_q;
  assign err         = err_q;

  // State, datapath and tick registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      pend_q      <= '0;
      rb_q        <= '0;
      current_q   <= RESET_PATTERN;
      err_q       <= 1'b0;
      rr_q        <= 1'b1;
      tick_cnt_q  <= '0;
      tick_pend_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      pend_q      <= pend_d;
      rb_q        <= rb_d;
      current_q   <= current_d;
      err_q       <= err_d;
      rr_q        <= rr_d;
      tick_cnt_q  <= tick_cnt_d;
      tick_pend_q <= tick_pend_d;
    end
  end

  // Next-state, arbitration and bus outputs
  always_comb begin
    state_d        = state_q;
    pend_d         = pend_q;
    rb_d           = rb_q;
    current_d      = current_q;
    err_d          = err_clr ? 1'b0 : err_q;
    rr_d           = rr_q;
    req0_ready     = 1'b0;
    req1_ready     = 1'b0;
    auto_grant     = 1'b0;
    pio_chipselect = 1'b0;
    pio_write_n    = 1'b1;
    pio_writedata  = '0;
    unique case (state_q)
      IDLE: begin
        if (grant0) begin
          req0_ready = 1'b1;
          pend_d     = req0_data;
          rr_d       = 1'b0;
          state_d    = WRITE;
        end else if (grant1) begin
          req1_ready = 1'b1;
          pend_d     = req1_data;
          rr_d       = 1'b1;
          state_d    = WRITE;
        end else if (auto_elig) begin
          auto_grant = 1'b1;
          pend_d     = {current_q[14:0], current_q[15]};
          state_d    = WRITE;
        end
      end
      WRITE: begin
        pio_chipselect = 1'b1;
        pio_write_n    = 1'b0;
        pio_writedata  = {16'h0000, pend_q};
        state_d        = READ;
      end
      READ: begin
        pio_chipselect = 1'b1;
        rb_d           = pio_readdata[15:0];
        state_d        = CHECK;
      end
      CHECK: begin
        // set overrides a simultaneous err_clr
        if (rb_q != pend_q) err_d = 1'b1;
        current_d = pend_q;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Auto-rotate tick counter; a wrap while a tick is already pending is dropped
  always_comb begin
    tick_cnt_d  = tick_cnt_q;
    tick_pend_d = tick_pend_q;
    if (!auto_en) begin
      tick_cnt_d  = '0;
      tick_pend_d = 1'b0;
    end else begin
      tick_cnt_d = tick_wrap ? '0 : tick_cnt_q + 1'b1;
      if (auto_grant)     tick_pend_d = 1'b0;
      else if (tick_wrap) tick_pend_d = 1'b1;
    end
  end

endmodule

// File: tb/tb_integration_led_sequencer.sv
// Scoreboarded bench for integration_led_sequencer with a behavioural PIO.
module tb_integration_led_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0_valid, req1_valid, req0_ready, req1_ready;
  logic [15:0] req0_data, req1_data;
  logic        auto_en, err_clr;
  logic [1:0]  pio_address;
  logic        pio_chipselect, pio_write_n;
  logic [31:0] pio_writedata, pio_readdata;
  logic        busy, err;
  logic [15:0] current;

  always #5 clk = ~clk;

  integration_led_sequencer #(.TICK_DIV(4), .RESET_PATTERN(16'h3136)) dut (
    .clk(clk), .reset(rst),
    .req0_valid(req0_valid), .req0_data(req0_data), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_data(req1_data), .req1_ready(req1_ready),
    .auto_en(auto_en), .err_clr(err_clr),
    .pio_address(pio_address), .pio_chipselect(pio_chipselect),
    .pio_write_n(pio_write_n), .pio_writedata(pio_writedata),
    .pio_readdata(pio_readdata),
    .busy(busy), .current(current), .err(err)
  );

  // PIO model: a write of 16'h00FF is stored as zero to provoke a mismatch
  logic [15:0] pio_reg;
  always @(posedge clk or posedge rst) begin
    if (rst) pio_reg <= 16'h3136;
    else if (pio_chipselect && !pio_write_n)
      pio_reg <= (pio_writedata[15:0] == 16'h00FF) ? 16'h0000 : pio_writedata[15:0];
  end
  assign pio_readdata = {16'hC0DE, pio_reg};

  typedef struct packed { logic [15:0] data; logic err; } exp_t;
  exp_t exp_q[$];

  int  n_cmp = 0, n_bad = 0;
  int  push_cnt = 0, done_cnt = 0, wr_cnt = 0, rd_cnt = 0, rdy0_cnt = 0;
  bit  mon_en = 1'b1;
  bit  last = 1'b1;              // last granted requester
  bit  model_err = 1'b0;
  logic [15:0] model_cur = 16'h3136;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic expect_write(input logic [15:0] d);
    if (d == 16'h00FF) model_err = 1'b1;
    exp_q.push_back({d, model_err});
    model_cur = d;
    push_cnt++;
  endtask

  function automatic logic [15:0] rotl(input logic [15:0] x);
    return (x << 1) | (x >> 15);
  endfunction

  // Monitor: each observed write must match the queue head, then a read,
  // an idle CHECK cycle, and the updated shadow/error.
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst && mon_en && pio_chipselect && !pio_write_n) begin
        wr_cnt++;
        if (exp_q.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL unexpected_write: got %h expected none", pio_writedata);
        end else begin
          e = exp_q.pop_front();
          chk("writedata", pio_writedata, {16'h0000, e.data});
          chk("address", {30'b0, pio_address}, 32'd0);
          chk("busy_write", {31'b0, busy}, 32'd1);
          @(negedge clk);
          chk("read_cycle", {30'b0, pio_chipselect, pio_write_n}, 32'd3);
          @(negedge clk);
          chk("check_idle", {30'b0, pio_chipselect, pio_write_n}, 32'd1);
          @(negedge clk);
          chk("current", {16'h0, current}, {16'h0, e.data});
          chk("err", {31'b0, err}, {31'b0, e.err});
          done_cnt++;
        end
      end
    end
  end

  initial begin : read_counter
    forever begin
      @(posedge clk);
      if (!rst && pio_chipselect && pio_write_n) rd_cnt++;
    end
  end

  initial begin : ready_counter
    forever begin
      @(negedge clk);
      #2;
      if (req0_ready) rdy0_cnt++;
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  // Present requests from a negedge and hold each valid until its grant.
  task automatic send(input bit v0, input bit v1, input logic [15:0] d0, input logic [15:0] d1);
    int unsigned b = 0;
    bit g0, g1;
    req0_valid = v0; req0_data = d0;
    req1_valid = v1; req1_data = d1;
    while ((req0_valid || req1_valid) && b < 100) begin
      #1;
      g0 = req0_ready; g1 = req1_ready;
      @(posedge clk); #1;
      if (g0) begin req0_valid = 1'b0; req0_data = 16'($urandom); end
      if (g1) begin req1_valid = 1'b0; req1_data = 16'($urandom); end
      @(negedge clk);
      b++;
    end
    if (b >= 100) begin
      n_cmp++; n_bad++;
      $display("FAIL send_timeout: got no grant expected grant");
      req0_valid = 1'b0; req1_valid = 1'b0;
    end
  endtask

  task automatic wait_drain();
    int unsigned b = 0;
    while (done_cnt != push_cnt && b < 400) begin @(negedge clk); b++; end
    chk("drain", done_cnt, push_cnt);
  endtask

  initial begin : main
    int target, grants, r0;
    bit first, g0, g1;
    int unsigned b;
    logic [15:0] d0, d1;

    rst = 1'b1; req0_valid = 0; req1_valid = 0; req0_data = '0; req1_data = '0;
    auto_en = 0; err_clr = 0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (8) @(negedge clk);
    chk("rst_current", {16'h0, current}, 32'h3136);
    chk("rst_err", {31'b0, err}, 32'd0);
    chk("rst_bus", {29'b0, pio_chipselect, pio_write_n, busy}, 32'd2);
    chk("rst_writedata", pio_writedata, 32'd0);
    chk("rst_ready", {30'b0, req0_ready, req1_ready}, 32'd0);
    chk("rst_no_activity", wr_cnt + rd_cnt, 32'd0);

    // single request
    r0 = rdy0_cnt;
    expect_write(16'hA5A5); last = 0;
    send(1, 0, 16'hA5A5, 16'h0);
    wait_drain();
    chk("ready0_pulses", rdy0_cnt - r0, 32'd1);

    // both held: grants alternate
    first = last ? 1'b0 : 1'b1;
    for (int i = 0; i < 6; i++)
      expect_write(((i % 2 == 0) ? first : !first) ? 16'h0002 : 16'h0001);
    last = !first;
    req0_valid = 1; req0_data = 16'h0001; req1_valid = 1; req1_data = 16'h0002;
    grants = 0; b = 0;
    while (grants < 6 && b < 100) begin
      #1; g0 = req0_ready; g1 = req1_ready;
      if (g0 || g1) grants++;
      @(posedge clk); #1;
      if (grants == 6) begin req0_valid = 0; req1_valid = 0; end
      @(negedge clk); b++;
    end
    chk("alt_grants", grants, 32'd6);
    req0_valid = 0; req1_valid = 0;
    wait_drain();

    // auto-rotate
    expect_write(16'h8001); last = 0;
    send(1, 0, 16'h8001, 16'h0);
    wait_drain();
    target = wr_cnt + 4;
    for (int i = 0; i < 4; i++) expect_write(rotl(model_cur));
    auto_en = 1;
    b = 0;
    while (wr_cnt < target && b < 200) begin @(negedge clk); b++; end
    auto_en = 0;
    chk("auto_writes", wr_cnt, target);
    wait_drain();
    repeat (12) @(negedge clk);
    chk("auto_stopped", wr_cnt, target);

    // error set, clear, and set-wins-over-clear
    expect_write(16'h00FF); last = 0;
    send(1, 0, 16'h00FF, 16'h0);
    wait_drain();
    err_clr = 1; @(posedge clk); #1; err_clr = 0; model_err = 0;
    chk("err_clr_alone", {31'b0, err}, 32'd0);
    expect_write(16'h00FF); last = 1;
    send(0, 1, 16'h0, 16'h00FF);
    @(posedge clk); @(posedge clk); #1 err_clr = 1;
    @(posedge clk); #1 err_clr = 0;
    wait_drain();
    @(negedge clk);
    err_clr = 1; @(posedge clk); #1; err_clr = 0; model_err = 0;
    chk("err_clr_after", {31'b0, err}, 32'd0);
    @(negedge clk);

    // random traffic
    for (int it = 0; it < 25; it++) begin
      d0 = 16'($urandom); d1 = 16'($urandom);
      if (d1 == d0) d1 = ~d0;
      case ($urandom_range(0, 2))
        0: begin expect_write(d0); last = 0; send(1, 0, d0, d1); end
        1: begin expect_write(d1); last = 1; send(0, 1, d0, d1); end
        default: begin
          if (last) begin expect_write(d0); expect_write(d1); last = 1; end
          else      begin expect_write(d1); expect_write(d0); last = 0; end
          send(1, 1, d0, d1);
        end
      endcase
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end
    wait_drain();

    // reset during WRITE
    mon_en = 0;
    @(negedge clk);
    req0_valid = 1; req0_data = 16'h1234;
    #1 chk("rst_test_grant", {31'b0, req0_ready}, 32'd1);
    @(posedge clk); #1 req0_valid = 0;
    @(negedge clk);
    chk("rst_test_write", {pio_chipselect, pio_write_n, 14'b0, pio_writedata[15:0]}, {2'b10, 14'b0, 16'h1234});
    r0 = rd_cnt;
    rst = 1;
    #1;
    chk("rst_mid_cs", {31'b0, pio_chipselect}, 32'd0);
    chk("rst_mid_busy", {31'b0, busy}, 32'd0);
    chk("rst_mid_current", {16'h0, current}, 32'h3136);
    @(posedge clk); @(posedge clk);
    @(negedge clk) rst = 0;
    repeat (4) @(negedge clk);
    chk("rst_no_read", rd_cnt, r0);
    chk("rst_idle", {30'b0, pio_chipselect, busy}, 32'd0);
    last = 1; model_err = 0; model_cur = 16'h3136;
    mon_en = 1;

    // pointer reset: req0 wins first
    expect_write(16'h0A0A); expect_write(16'h0B0B); last = 1;
    send(1, 1, 16'h0A0A, 16'h0B0B);
    wait_drain();
    chk("queue_empty", exp_q.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
